branch_predict_local_nbit: RTL and testbench
============================================

Name: branch_predict_local_nbit

Overview:
Parametrised local-history branch predictor, the next generation of the 2-bit local predictor in the fetch stage. It adds configurable counter width, a selectable PC hash and a confidence output. A sequential table-initialisation FSM replaces the single-cycle array reset. Saturating branch and mispredict counters feed the perf-counter CSRs. Lookup happens in F; training arrives from E.

Parameters:
PHT_INDEX_BITS, 10, log2 PHT depth
BHT_INDEX_BITS, 3, log2 BHT depth
BHR_BITS, 4, per-entry local history length; must be < PHT_INDEX_BITS
PC_TAIL, 2, lowest PC bit used in hashing/indexing
CTR_BITS, 2, PHT saturating counter width, 2..4
HASH_MODE, 0, 0 = direct PC slice, 1 = XOR fold
CNT_BITS, 32, perf counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (asserted at 0)
pcF  input  32  fetch PC
branchE  input  1  resolved branch in E, train this cycle
BHT_indexE  input  BHT_INDEX_BITS  BHT index carried from F
PHT_indexE  input  PHT_INDEX_BITS  PHT index carried from F
actually_takenE  input  1  resolved direction
mispredictE  input  1  F prediction was wrong
predict_takeF  output  1  predicted taken
predict_confF  output  1  counter saturated (0 or max)
pc_hashingF  output  BHT_INDEX_BITS  BHT index for pcF
PHT_indexF  output  PHT_INDEX_BITS  PHT index for pcF
readyF  output  1  tables initialised, predictions valid
branch_count  output  CNT_BITS  trained branches
mispredict_count  output  CNT_BITS  trained mispredicts

Behaviour:
- Hash, HASH_MODE=0: pc_hashingF = pcF[PC_TAIL+BHT_INDEX_BITS-1:PC_TAIL].
- Hash, HASH_MODE=1: pc_hashingF = that slice XOR pcF[PC_TAIL+2*BHT_INDEX_BITS-1:PC_TAIL+BHT_INDEX_BITS].
- PHT_indexF = {pcF[PC_TAIL+SEG-1:PC_TAIL], BHT[pc_hashingF]}, where SEG = PHT_INDEX_BITS-BHR_BITS.
- All F outputs are combinational from current array state.
- FSM states: INIT, RUN.
- Reset asserted (async): state=INIT, init index=0, perf counters=0, readyF=0. This applies mid-operation too; a new init sweep starts on release.
- INIT: one entry per cycle. Write PHT[idx] = 2^(CTR_BITS-1) (weakly taken). If idx < BHT depth, also write BHT[idx] = 0.
- INIT length: sweep covers 2^max(PHT_INDEX_BITS, BHT_INDEX_BITS) entries. After the last entry: RUN, readyF=1 from the next cycle.
- During INIT: predict_takeF=0, predict_confF=0, branchE ignored (no table or counter update).
- RUN, branchE=1, PHT: PHT[PHT_indexE] increments if actually_takenE, else decrements. Saturates at 0 and 2^CTR_BITS-1.
- RUN, branchE=1, BHT: BHT[BHT_indexE] = {BHT[BHT_indexE][BHR_BITS-2:0], actually_takenE}.
- predict_takeF = counter MSB.
- predict_confF = counter is 0 or all-ones.
- Same-cycle F lookup and E update to the same entry: F sees the pre-update value; the write is visible next cycle. No bypass.
- branch_count +1 per RUN branchE. mispredict_count +1 per RUN branchE&&mispredictE. Both saturate at all-ones; no wrap.
- mispredictE without branchE is ignored.
- Array writes use nonblocking assignments only. Arrays have no reset of their own; INIT sweep is the only clear.

Test Plan:
- PHT_INDEX_BITS=4, BHT_INDEX_BITS=3: release reset -> readyF=0 for exactly 16 cycles, then 1. Any pcF -> predict_takeF=1, predict_confF=0.
- CTR_BITS=2, after init: two branchE not-taken at PHT_indexE=5 -> lookup hitting index 5 gives predict_takeF=0, predict_confF=1. One taken -> predict 0, conf 0.
- CTR_BITS=3: ten taken updates at one index -> counter 7, conf=1. One not-taken -> counter 6, predict_takeF=1, conf=0.
- BHR_BITS=4, BHT_indexE=2: outcomes T,N,T,T -> pcF hashing to 2 gives BHT=4'b1011, PHT_indexF low 4 bits = 1011.
- Same-cycle lookup/update of counter value 1 with taken -> F sees 0 that cycle, 1 next cycle. Reset pulsed 5 cycles into RUN -> readyF drops asynchronously, perf counters read 0, full init sweep repeats.
- CNT_BITS=4: 20 branchE with mispredictE=1 -> both counters hold 15.

Source files
------------

// File: rtl/branch_predict_local_nbit.sv
// Local-history branch predictor: per-PC history table (BHT) indexes a table of
// CTR_BITS saturating counters (PHT). Tables are cleared by a one-entry-per-cycle sweep.
module branch_predict_local_nbit #(
  parameter int PHT_INDEX_BITS = 10,
  parameter int BHT_INDEX_BITS = 3,
  parameter int BHR_BITS       = 4,
  parameter int PC_TAIL        = 2,
  parameter int CTR_BITS       = 2,
  parameter int HASH_MODE      = 0,
  parameter int CNT_BITS       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  input  logic                      branchE,
  input  logic [BHT_INDEX_BITS-1:0] BHT_indexE,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexE,
  input  logic                      actually_takenE,
  input  logic                      mispredictE,
  output logic                      predict_takeF,
  output logic                      predict_confF,
  output logic [BHT_INDEX_BITS-1:0] pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  output logic                      readyF,
  output logic [CNT_BITS-1:0]       branch_count,
  output logic [CNT_BITS-1:0]       mispredict_count,
  output logic                      fsm_state_dbg
);

  localparam int SEG       = PHT_INDEX_BITS - BHR_BITS;
  localparam int IDX_BITS  = (PHT_INDEX_BITS > BHT_INDEX_BITS) ? PHT_INDEX_BITS : BHT_INDEX_BITS;
  localparam int PHT_DEPTH = 1 << PHT_INDEX_BITS;
  localparam int BHT_DEPTH = 1 << BHT_INDEX_BITS;

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   init_idx_q, init_idx_d;
  logic [CNT_BITS-1:0]   branch_count_q, branch_count_d;
  logic [CNT_BITS-1:0]   mispredict_count_q, mispredict_count_d;

  logic [CTR_BITS-1:0]   pht_q [PHT_DEPTH];
  logic [BHR_BITS-1:0]   bht_q [BHT_DEPTH];

  logic                      pht_we, bht_we;
  logic [PHT_INDEX_BITS-1:0] pht_waddr;
  logic [BHT_INDEX_BITS-1:0] bht_waddr;
  logic [CTR_BITS-1:0]       pht_wdata;
  logic [BHR_BITS-1:0]       bht_wdata;

  logic [CTR_BITS-1:0]   ctr_f, ctr_e;
  logic [BHR_BITS-1:0]   hist_e;
  logic                  unused_pc;

  // ---------------- F-stage lookup (combinational, no E bypass) ----------------
  generate
    if (HASH_MODE == 1) begin : g_hash_xor
      assign pc_hashingF = pcF[PC_TAIL+BHT_INDEX_BITS-1:PC_TAIL]
                         ^ pcF[PC_TAIL+2*BHT_INDEX_BITS-1:PC_TAIL+BHT_INDEX_BITS];
    end else begin : g_hash_direct
      assign pc_hashingF = pcF[PC_TAIL+BHT_INDEX_BITS-1:PC_TAIL];
    end
  endgenerate

  assign PHT_indexF = {pcF[PC_TAIL+SEG-1:PC_TAIL], bht_q[pc_hashingF]};
  assign ctr_f      = pht_q[PHT_indexF];
  assign unused_pc  = ^pcF;

  assign readyF        = (state_q == ST_RUN);
  assign predict_takeF = readyF & ctr_f[CTR_BITS-1];
  assign predict_confF = readyF & ((ctr_f == '0) || (ctr_f == CTR_MAX));

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  assign fsm_state_dbg    = state_q;

  assign ctr_e  = pht_q[PHT_indexE];
  assign hist_e = bht_q[BHT_indexE];

  // ---------------- next state, table writes, perf counters ----------------
  always_comb begin
    state_d            = state_q;
    init_idx_d         = init_idx_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    pht_we             = 1'b0;
    pht_waddr          = '0;
    pht_wdata          = '0;
    bht_we             = 1'b0;
    bht_waddr          = '0;
    bht_wdata          = '0;

    unique case (state_q)
      ST_INIT: begin
        // Sweep spans the larger table; the smaller one is written only while in range.
        pht_we     = ((init_idx_q >> PHT_INDEX_BITS) == '0);
        pht_waddr  = init_idx_q[PHT_INDEX_BITS-1:0];
        pht_wdata  = CTR_WEAK;
        bht_we     = ((init_idx_q >> BHT_INDEX_BITS) == '0);
        bht_waddr  = init_idx_q[BHT_INDEX_BITS-1:0];
        bht_wdata  = '0;
        init_idx_d = init_idx_q + IDX_ONE;
        if (init_idx_q == IDX_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (branchE) begin
          pht_we    = 1'b1;
          pht_waddr = PHT_indexE;
          if (actually_takenE) pht_wdata = (ctr_e == CTR_MAX) ? ctr_e : ctr_e + CTR_ONE;
          else                 pht_wdata = (ctr_e == '0)      ? ctr_e : ctr_e - CTR_ONE;
          bht_we    = 1'b1;
          bht_waddr = BHT_indexE;
          bht_wdata = {hist_e[BHR_BITS-2:0], actually_takenE};
          if (branch_count_q != CNT_MAX) branch_count_d = branch_count_q + CNT_ONE;
          if (mispredictE && (mispredict_count_q != CNT_MAX))
            mispredict_count_d = mispredict_count_q + CNT_ONE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= ST_INIT;
      init_idx_q         <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      init_idx_q         <= init_idx_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Tables carry no reset; the INIT sweep is their only clear.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    if (bht_we) bht_q[bht_waddr] <= bht_wdata;
  end

endmodule

// File: tb/tb_branch_predict_local_nbit.sv
// Directed bench: two predictor configurations (small 2-bit/4-bit-counter and
// 3-bit-counter/XOR-hash) driven from negedge, checked against hand-computed values.
module tb_branch_predict_local_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Config A: PHT 16, BHT 8, 2-bit history, 2-bit counters, 4-bit perf counters.
  logic        a_rst, a_branchE, a_taken, a_misp;
  logic [31:0] a_pcF;
  logic [2:0]  a_bht_idx;
  logic [3:0]  a_pht_idx;
  logic        a_take, a_conf, a_ready, a_state;
  logic [2:0]  a_hash;
  logic [3:0]  a_phtf, a_bcnt, a_mcnt;

  // Config B: PHT 64, BHT 8, 4-bit history, 3-bit counters, XOR hash.
  logic        b_rst, b_branchE, b_taken, b_misp;
  logic [31:0] b_pcF;
  logic [2:0]  b_bht_idx;
  logic [5:0]  b_pht_idx;
  logic        b_take, b_conf, b_ready, b_state;
  logic [2:0]  b_hash;
  logic [5:0]  b_phtf;
  logic [31:0] b_bcnt, b_mcnt;

  branch_predict_local_nbit #(
    .PHT_INDEX_BITS(4), .BHT_INDEX_BITS(3), .BHR_BITS(2), .PC_TAIL(2),
    .CTR_BITS(2), .HASH_MODE(0), .CNT_BITS(4)
  ) dut_a (
    .clk(clk), .rst(a_rst), .pcF(a_pcF), .branchE(a_branchE),
    .BHT_indexE(a_bht_idx), .PHT_indexE(a_pht_idx),
    .actually_takenE(a_taken), .mispredictE(a_misp),
    .predict_takeF(a_take), .predict_confF(a_conf), .pc_hashingF(a_hash),
    .PHT_indexF(a_phtf), .readyF(a_ready), .branch_count(a_bcnt),
    .mispredict_count(a_mcnt), .fsm_state_dbg(a_state)
  );

  branch_predict_local_nbit #(
    .PHT_INDEX_BITS(6), .BHT_INDEX_BITS(3), .BHR_BITS(4), .PC_TAIL(2),
    .CTR_BITS(3), .HASH_MODE(1), .CNT_BITS(32)
  ) dut_b (
    .clk(clk), .rst(b_rst), .pcF(b_pcF), .branchE(b_branchE),
    .BHT_indexE(b_bht_idx), .PHT_indexE(b_pht_idx),
    .actually_takenE(b_taken), .mispredictE(b_misp),
    .predict_takeF(b_take), .predict_confF(b_conf), .pc_hashingF(b_hash),
    .PHT_indexF(b_phtf), .readyF(b_ready), .branch_count(b_bcnt),
    .mispredict_count(b_mcnt), .fsm_state_dbg(b_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One training beat: branchE high across exactly one posedge.
  task automatic train_a(input logic [2:0] bi, input logic [3:0] pi, input logic t, input logic m);
    a_bht_idx = bi; a_pht_idx = pi; a_taken = t; a_misp = m; a_branchE = 1'b1;
    @(negedge clk);
    a_branchE = 1'b0; a_misp = 1'b0;
    #1;
  endtask

  task automatic train_b(input logic [2:0] bi, input logic [5:0] pi, input logic t);
    b_bht_idx = bi; b_pht_idx = pi; b_taken = t; b_misp = 1'b0; b_branchE = 1'b1;
    @(negedge clk);
    b_branchE = 1'b0;
    #1;
  endtask

  // Counts posedges from reset release until readyF; bounded so a stuck FSM fails the check.
  task automatic wait_ready_a(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        check_eq("a_init_take_gated", 32'(a_take), 32'd0);
        check_eq("a_init_conf_gated", 32'(a_conf), 32'd0);
      end
      if (a_ready) break;
    end
  endtask

  task automatic wait_ready_b(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (b_ready) break;
    end
  endtask

  int n;

  initial begin
    a_rst = 1'b0; a_pcF = '0; a_branchE = 1'b0; a_bht_idx = '0; a_pht_idx = '0;
    a_taken = 1'b0; a_misp = 1'b0;
    b_rst = 1'b0; b_pcF = '0; b_branchE = 1'b0; b_bht_idx = '0; b_pht_idx = '0;
    b_taken = 1'b0; b_misp = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("a_reset_ready", 32'(a_ready), 32'd0);
    check_eq("a_reset_bcnt",  32'(a_bcnt),  32'd0);
    check_eq("a_reset_take",  32'(a_take),  32'd0);

    // Init sweep length and weakly-taken start
    a_rst = 1'b1;
    wait_ready_a(n);
    check_eq("a_init_cycles", 32'(n), 32'd16);
    a_pcF = 32'h0; #1;
    check_eq("a_weak_take_pc0", 32'(a_take), 32'd1);
    check_eq("a_weak_conf_pc0", 32'(a_conf), 32'd0);
    a_pcF = 32'h3c; #1;
    check_eq("a_weak_take_pc3c", 32'(a_take), 32'd1);

    // bht[1]=01 so pc 0x4 maps to PHT index {01,01}=5; then drive pht[5] 2->1->0
    train_a(3'd1, 4'd15, 1'b1, 1'b0);
    train_a(3'd7, 4'd5, 1'b0, 1'b0);
    train_a(3'd7, 4'd5, 1'b0, 1'b0);
    a_pcF = 32'h4; #1;
    check_eq("a_phtf_idx5",    32'(a_phtf), 32'd5);
    check_eq("a_strong_nt_take", 32'(a_take), 32'd0);
    check_eq("a_strong_nt_conf", 32'(a_conf), 32'd1);
    train_a(3'd7, 4'd5, 1'b1, 1'b0);
    check_eq("a_ctr1_take", 32'(a_take), 32'd0);
    check_eq("a_ctr1_conf", 32'(a_conf), 32'd0);

    // Same-cycle lookup and update of pht[5] (value 1, taken): no bypass
    a_bht_idx = 3'd7; a_pht_idx = 4'd5; a_taken = 1'b1; a_branchE = 1'b1; #1;
    check_eq("a_samecyc_pre", 32'(a_take), 32'd0);
    @(negedge clk);
    a_branchE = 1'b0; #1;
    check_eq("a_samecyc_post", 32'(a_take), 32'd1);
    check_eq("a_bcnt_5", 32'(a_bcnt), 32'd5);
    check_eq("a_mcnt_0", 32'(a_mcnt), 32'd0);

    // mispredictE without branchE is ignored
    a_misp = 1'b1;
    @(negedge clk);
    a_misp = 1'b0; #1;
    check_eq("a_misp_alone", 32'(a_mcnt), 32'd0);

    // Perf counter saturation at 4 bits
    for (int i = 0; i < 20; i++) train_a(3'd0, 4'd0, 1'b1, 1'b1);
    check_eq("a_bcnt_sat", 32'(a_bcnt), 32'd15);
    check_eq("a_mcnt_sat", 32'(a_mcnt), 32'd15);

    // Asynchronous reset mid-RUN, then a full sweep with branchE held (must be ignored)
    @(posedge clk); #2;
    a_rst = 1'b0; #1;
    check_eq("a_async_ready", 32'(a_ready), 32'd0);
    check_eq("a_async_bcnt",  32'(a_bcnt),  32'd0);
    check_eq("a_async_mcnt",  32'(a_mcnt),  32'd0);
    @(negedge clk);
    a_bht_idx = 3'd1; a_pht_idx = 4'd4; a_taken = 1'b0; a_misp = 1'b1; a_branchE = 1'b1;
    a_rst = 1'b1;
    wait_ready_a(n);
    a_branchE = 1'b0; a_misp = 1'b0; #1;
    check_eq("a_reinit_cycles", 32'(n), 32'd16);
    check_eq("a_reinit_bcnt", 32'(a_bcnt), 32'd0);
    check_eq("a_reinit_mcnt", 32'(a_mcnt), 32'd0);
    a_pcF = 32'h4; #1;
    check_eq("a_reinit_phtf", 32'(a_phtf), 32'd4);
    check_eq("a_reinit_take", 32'(a_take), 32'd1);
    check_eq("a_reinit_conf", 32'(a_conf), 32'd0);

    // Config B: 64-entry sweep, XOR hash, 4-bit history, 3-bit counters
    @(negedge clk);
    b_rst = 1'b1;
    wait_ready_b(n);
    check_eq("b_init_cycles", 32'(n), 32'd64);
    b_pcF = 32'he4; #1;
    check_eq("b_hash_xor", 32'(b_hash), 32'd6);
    b_pcF = 32'h0; #1;
    check_eq("b_weak_take", 32'(b_take), 32'd1);
    check_eq("b_weak_conf", 32'(b_conf), 32'd0);

    train_b(3'd2, 6'd63, 1'b1);
    train_b(3'd2, 6'd63, 1'b0);
    train_b(3'd2, 6'd63, 1'b1);
    train_b(3'd2, 6'd63, 1'b1);
    b_pcF = 32'h8; #1;
    check_eq("b_hash_2",     32'(b_hash), 32'd2);
    check_eq("b_phtf_hist",  32'(b_phtf), 32'b101011);

    // bht[0] becomes 1111, so pc 0 looks up PHT index 15; counter 4 saturates at 7
    for (int i = 0; i < 10; i++) train_b(3'd0, 6'd15, 1'b1);
    b_pcF = 32'h0; #1;
    check_eq("b_phtf_15",   32'(b_phtf), 32'd15);
    check_eq("b_sat_take",  32'(b_take), 32'd1);
    check_eq("b_sat_conf",  32'(b_conf), 32'd1);
    train_b(3'd5, 6'd15, 1'b0);
    check_eq("b_ctr6_take", 32'(b_take), 32'd1);
    check_eq("b_ctr6_conf", 32'(b_conf), 32'd0);
    check_eq("b_bcnt_15",   b_bcnt, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
